// File: rtl/pio_in_debounced.sv
// Avalon-MM input port: per-channel synchroniser, counter debounce, edge capture
// with write-1-to-clear, and a maskable level interrupt.
module pio_in_debounced #(
  parameter int unsigned       WIDTH           = 4,
  parameter int unsigned       SYNC_STAGES     = 2,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int unsigned       CNT_W           = 16,
  parameter int unsigned       EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0]  RESET_LEVEL     = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int unsigned      DATA_W  = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync_out;
  logic [CNT_W-1:0]  cnt_q [WIDTH];
  logic [WIDTH-1:0]  deb_q;
  logic [WIDTH-1:0]  deb_dly_q;
  logic [WIDTH-1:0]  irqmask_q;
  logic [WIDTH-1:0]  edgecap_q;
  logic [WIDTH-1:0]  edge_hit;
  logic [WIDTH-1:0]  edgecap_clr;
  logic              wr_en;
  logic [DATA_W-1:0] rd_mux;
  logic              unused_wdata;

  // Metastability synchroniser chain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_LEVEL;
    end else begin
      sync_q[0] <= in_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Per-bit debounce: a new level is accepted only after an unbroken stable run
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      deb_q     <= RESET_LEVEL;
      deb_dly_q <= RESET_LEVEL;
    end else begin
      deb_dly_q <= deb_q;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (sync_out[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          deb_q[i] <= sync_out[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    edge_hit = '0;
    case (EDGE_TYPE)
      0:       edge_hit = deb_q & ~deb_dly_q;
      1:       edge_hit = ~deb_q & deb_dly_q;
      default: edge_hit = deb_q ^ deb_dly_q;
    endcase
  end

  assign wr_en       = chipselect & ~write_n;
  assign edgecap_clr = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // Control registers; a fresh edge overrides a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      if (wr_en && (address == 2'd2)) irqmask_q <= writedata[WIDTH-1:0];
      edgecap_q <= (edgecap_q & ~edgecap_clr) | edge_hit;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux = DATA_W'(deb_q);
      2'd2:    rd_mux = DATA_W'(irqmask_q);
      2'd3:    rd_mux = DATA_W'(edgecap_q);
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  assign irq = |(edgecap_q & irqmask_q);

  // Upper write-data bits have no destination
  assign unused_wdata = ^writedata;

endmodule

// File: tb/tb_pio_in_debounced.sv
// Directed bench for pio_in_debounced with a sample-window reference model.
module tb_pio_in_debounced;

  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HD   = SYNC + DEB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = 4'hF;
  logic        irq;

  int total = 0;
  int bad   = 0;

  // Reference state: pin history, accepted level, previous level, registers
  logic [W-1:0] hq [HD];
  logic [W-1:0] m_deb  = 4'hF;
  logic [W-1:0] m_prev = 4'hF;
  logic [W-1:0] m_mask = '0;
  logic [W-1:0] m_ecap = '0;
  logic [31:0]  m_rd   = '0;

  pio_in_debounced #(
    .WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .CNT_W(16),
    .EDGE_TYPE(1), .RESET_LEVEL(4'hF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < int'(HD); j++) hq[j] = 4'hF;
    m_deb = 4'hF; m_prev = 4'hF; m_mask = '0; m_ecap = '0; m_rd = '0;
  endtask

  // A level is accepted when the last DEB synchronised samples all disagree with it.
  // hq[j] holds the pin value sampled j+1 edges ago.
  task automatic model_step();
    logic [W-1:0] nd;
    logic [W-1:0] clr;
    logic [W-1:0] falls;
    logic         all_diff;
    nd = m_deb;
    for (int b = 0; b < int'(W); b++) begin
      all_diff = 1'b1;
      for (int j = int'(SYNC) - 1; j < int'(SYNC + DEB) - 1; j++)
        if (hq[j][b] == m_deb[b]) all_diff = 1'b0;
      if (all_diff) nd[b] = ~m_deb[b];
    end
    falls = ~m_deb & m_prev;
    case (address)
      2'd0:    m_rd = {28'd0, m_deb};
      2'd2:    m_rd = {28'd0, m_mask};
      2'd3:    m_rd = {28'd0, m_ecap};
      default: m_rd = '0;
    endcase
    clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ecap = (m_ecap & ~clr) | falls;
    if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
    m_prev = m_deb;
    m_deb  = nd;
    for (int j = int'(HD) - 1; j > 0; j--) hq[j] = hq[j-1];
    hq[0] = in_port;
  endtask

  // Advance n cycles; model on the rising edge, compare on the falling edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset_n) model_step();
      @(negedge clk);
      check("model_readdata", readdata, m_rd);
      check("model_irq", {31'd0, irq}, {31'd0, |(m_ecap & m_mask)});
    end
  endtask

  task automatic set_reset(input logic v);
    reset_n = v;
    if (!v) model_reset();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    cyc(1);
    chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    cyc(1);
    check(name, readdata, exp);
    address = 2'd0;
  endtask

  initial begin
    model_reset();
    #1;
    set_reset(1'b0);
    cyc(2);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    set_reset(1'b1);
    rd_chk("idle_addr0", 2'd0, 32'hF);
    rd_chk("addr1_zero", 2'd1, 32'h0);

    // Bit0 falls; accepted five edges after first sample
    in_port = 4'hE;
    cyc(6);
    check("deb_not_yet", readdata, 32'hF);
    cyc(1);
    check("deb_accepted", readdata, 32'hE);
    rd_chk("ecap_bit0", 2'd3, 32'h1);
    check("irq_masked", {31'd0, irq}, 32'h0);

    // Clear, rising edge ignored, then masked falling edge raises irq
    wr(2'd3, 32'h1);
    check("irq_after_clr", {31'd0, irq}, 32'h0);
    in_port = 4'hF;
    cyc(10);
    rd_chk("rise_ignored", 2'd3, 32'h0);
    wr(2'd2, 32'h1);
    rd_chk("mask_read", 2'd2, 32'h1);
    in_port = 4'hE;
    cyc(10);
    check("irq_set", {31'd0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("irq_cleared", {31'd0, irq}, 32'h0);
    rd_chk("ecap_cleared", 2'd3, 32'h0);

    // Three-cycle glitch on bit1 is rejected
    in_port = 4'hC;
    cyc(3);
    in_port = 4'hE;
    cyc(10);
    rd_chk("glitch_deb", 2'd0, 32'hE);
    rd_chk("glitch_ecap", 2'd3, 32'h0);

    // Five-cycle low on bit1 is accepted and captured
    in_port = 4'hC;
    cyc(5);
    in_port = 4'hE;
    cyc(12);
    rd_chk("pulse5_ecap", 2'd3, 32'h2);
    rd_chk("pulse5_deb", 2'd0, 32'hE);

    // Clear of bits 1,2 lands on the bit2 capture edge: bit2 survives
    in_port = 4'hA;
    cyc(6);
    wr(2'd3, 32'h6);
    rd_chk("set_beats_clr", 2'd3, 32'h4);
    wr(2'd3, 32'h8);
    rd_chk("write0_keeps", 2'd3, 32'h4);

    // Reset mid-debounce
    wr(2'd2, 32'h4);
    check("irq_bit2", {31'd0, irq}, 32'h1);
    in_port = 4'h2;
    cyc(4);
    set_reset(1'b0);
    in_port = 4'hF;
    cyc(1);
    check("midreset_rd", readdata, 32'h0);
    check("midreset_irq", {31'd0, irq}, 32'h0);
    set_reset(1'b1);
    cyc(12);
    rd_chk("post_reset_deb", 2'd0, 32'hF);
    rd_chk("post_reset_ecap", 2'd3, 32'h0);
    rd_chk("post_reset_mask", 2'd2, 32'h0);
    check("post_reset_irq", {31'd0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
